// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoder definitions: immediate format codes, the default NOP word
// and the signed immediate limits used by the range checker.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        IMM_U = 3'd0,
        IMM_J = 3'd1,
        IMM_I = 3'd2,
        IMM_S = 3'd3,
        IMM_B = 3'd4
    } imm_type_e;

    // ADDI x0,x0,0
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

    localparam int J_IMM_MIN = -(1 << 20);
    localparam int J_IMM_MAX = (1 << 20) - 2;
    localparam int I_IMM_MIN = -2048;
    localparam int I_IMM_MAX = 2047;
    localparam int S_IMM_MIN = -2048;
    localparam int S_IMM_MAX = 2047;
    localparam int B_IMM_MIN = -4096;
    localparam int B_IMM_MAX = 4094;

endpackage

// File: rtl/rv_imm_range_chk.sv
// Combinational legality check of an immediate against its instruction format:
// signed range plus the even-alignment rule of the branch/jump formats.
module rv_imm_range_chk
    import rv_isa_pkg::*;
(
    input  logic [2:0]  inst_type,
    input  logic [31:0] imm,
    output logic        ok
);

    logic signed [31:0] imm_s;

    assign imm_s = $signed(imm);

    always_comb begin
        ok = 1'b0;
        case (inst_type)
            IMM_U: ok = (imm[11:0] == 12'd0);
            IMM_J: ok = (imm_s >= J_IMM_MIN) && (imm_s <= J_IMM_MAX) && !imm[0];
            IMM_I: ok = (imm_s >= I_IMM_MIN) && (imm_s <= I_IMM_MAX);
            IMM_S: ok = (imm_s >= S_IMM_MIN) && (imm_s <= S_IMM_MAX);
            IMM_B: ok = (imm_s >= B_IMM_MIN) && (imm_s <= B_IMM_MAX) && !imm[0];
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder (U/J/I/S/B); illegal requests emit a flagged NOP.
// Optional RV_INST_ENC_STATS_EN adds saturating enc_count/err_count output counters.
module rv_inst_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_inst_type,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
`ifdef RV_INST_ENC_STATS_EN
    ,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
`endif
);

    logic        s1_valid_reg;
    logic [2:0]  s1_type_reg;
    logic [31:0] s1_imm_reg;
    logic [4:0]  s1_rd_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [2:0]  s1_funct3_reg;
    logic [6:0]  s1_opcode_reg;
    logic        s1_ok_reg;

    logic        req_ok;
    logic        s1_load;
    logic        s2_load;
    logic [31:0] inst_next;

    rv_imm_range_chk u_range_chk (
        .inst_type (in_inst_type),
        .imm       (in_imm),
        .ok        (req_ok)
    );

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        inst_next = NOP_INST;
        case (s1_type_reg)
            IMM_U: inst_next = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
            IMM_J: inst_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
            IMM_I: inst_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                s1_rd_reg, s1_opcode_reg};
            IMM_S: inst_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg,
                                s1_funct3_reg, s1_imm_reg[4:0], s1_opcode_reg};
            IMM_B: inst_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg,
                                s1_rs1_reg, s1_funct3_reg, s1_imm_reg[4:1],
                                s1_imm_reg[11], s1_opcode_reg};
            default: inst_next = NOP_INST;
        endcase
        if (!s1_ok_reg) begin
            inst_next = NOP_INST;
        end
    end

    // Payload registers only move with a valid word so a held output never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_type_reg   <= 3'd0;
            s1_imm_reg    <= 32'd0;
            s1_rd_reg     <= 5'd0;
            s1_rs1_reg    <= 5'd0;
            s1_rs2_reg    <= 5'd0;
            s1_funct3_reg <= 3'd0;
            s1_opcode_reg <= 7'd0;
            s1_ok_reg     <= 1'b0;
            out_valid     <= 1'b0;
            out_inst      <= 32'd0;
            out_err       <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_type_reg   <= in_inst_type;
                    s1_imm_reg    <= in_imm;
                    s1_rd_reg     <= in_rd;
                    s1_rs1_reg    <= in_rs1;
                    s1_rs2_reg    <= in_rs2;
                    s1_funct3_reg <= in_funct3;
                    s1_opcode_reg <= in_opcode;
                    s1_ok_reg     <= req_ok;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_inst <= inst_next;
                    out_err  <= !s1_ok_reg;
                end
            end
        end
    end

`ifdef RV_INST_ENC_STATS_EN
    logic out_fire;

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= 16'd0;
            err_count <= 16'd0;
        end else if (out_fire) begin
            if (enc_count != 16'hFFFF) begin
                enc_count <= enc_count + 16'd1;
            end
            if (out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench for rv_inst_encoder: format-level reference model plus
// hand-computed literal expectations; define RV_INST_ENC_STATS_EN to cover the counters.
module tb_rv_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_inst_type;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
`ifdef RV_INST_ENC_STATS_EN
    logic [15:0] enc_count;
    logic [15:0] err_count;
    int          model_enc = 0;
    int          model_err = 0;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int out_seen   = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        bit          lit_v;
        logic [31:0] lit_inst;
        logic        lit_err;
    } exp_t;

    exp_t sb[$];

    bit          cur_lit_v;
    logic [31:0] cur_lit_inst;
    logic        cur_lit_err;

    rv_inst_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst_type (in_inst_type),
        .in_imm       (in_imm),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_funct3    (in_funct3),
        .in_opcode    (in_opcode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_err      (out_err)
`ifdef RV_INST_ENC_STATS_EN
        ,
        .enc_count    (enc_count),
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: legality from signed integer ranges, bit placement by shift-and-mask.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] imm,
                                          input logic [31:0] rd, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [31:0] f3,
                                          input logic [31:0] op);
        int          s;
        bit          ok;
        logic [31:0] w;
        s  = $signed(imm);
        ok = 1'b0;
        w  = 32'd0;
        case (t)
            3'd0: begin
                ok = ((imm & 32'h0000_0FFF) == 32'd0);
                w  = (imm & 32'hFFFF_F000) | (rd << 7) | op;
            end
            3'd1: begin
                ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && ((s % 2) == 0);
                w  = op | (rd << 7) | (((imm >> 12) & 32'hFF) << 12)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 20) & 32'h1) << 31);
            end
            3'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
            end
            3'd3: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = op | ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                   | (((imm >> 5) & 32'h7F) << 25);
            end
            3'd4: begin
                ok = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
                w  = op | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                   | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) w = 32'h0000_0013;
        return {!ok, w};
    endfunction

    // Single compare process: every cycle the output is valid it is checked against the head.
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (!rst_n) begin
            sb.delete();
        end else begin
`ifdef RV_INST_ENC_STATS_EN
            vectors++;
            if (enc_count !== model_enc[15:0] || err_count !== model_err[15:0]) begin
                miscompares++;
                $display("FAIL stats: enc_count=%0d err_count=%0d expected %0d/%0d",
                         enc_count, err_count, model_enc, model_err);
            end
`endif
            if (out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_out: out_valid=1 inst=%h with no pending request", out_inst);
                end else begin
                    e = sb[0];
                    if (out_inst !== e.inst || out_err !== e.err) begin
                        miscompares++;
                        $display("FAIL model_cmp: got inst=%h err=%b expected inst=%h err=%b",
                                 out_inst, out_err, e.inst, e.err);
                    end
                    if (e.lit_v) begin
                        vectors++;
                        if (out_inst !== e.lit_inst || out_err !== e.lit_err) begin
                            miscompares++;
                            $display("FAIL literal_cmp: got inst=%h err=%b expected inst=%h err=%b",
                                     out_inst, out_err, e.lit_inst, e.lit_err);
                        end
                    end
                    if (out_ready) begin
                        out_seen++;
                        $display("out #%0d inst=%h err=%b", out_seen, out_inst, out_err);
                        void'(sb.pop_front());
`ifdef RV_INST_ENC_STATS_EN
                        model_enc++;
                        if (out_err) model_err++;
`endif
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = model(in_inst_type, in_imm, {27'd0, in_rd}, {27'd0, in_rs1},
                          {27'd0, in_rs2}, {29'd0, in_funct3}, {25'd0, in_opcode});
                e.inst     = m[31:0];
                e.err      = m[32];
                e.lit_v    = cur_lit_v;
                e.lit_inst = cur_lit_inst;
                e.lit_err  = cur_lit_err;
                sb.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int t, input logic [31:0] imm, input int rd, input int rs1,
                        input int rs2, input int f3, input int op, input bit lv,
                        input logic [31:0] li, input logic le);
        bit acc;
        int n;
        in_inst_type = t[2:0];
        in_imm       = imm;
        in_rd        = rd[4:0];
        in_rs1       = rs1[4:0];
        in_rs2       = rs2[4:0];
        in_funct3    = f3[2:0];
        in_opcode    = op[6:0];
        cur_lit_v    = lv;
        cur_lit_inst = li;
        cur_lit_err  = le;
        in_valid     = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready=0 for %0d cycles, expected acceptance", n);
        end
        in_valid = 1'b0;
        $display("in type=%0d imm=%h rd=%0d rs1=%0d rs2=%0d f3=%0d op=%h", t, imm, rd, rs1, rs2, f3, op);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d words still pending, expected 0", sb.size());
        end
        #1;
    endtask

    initial begin
        int t;
        int pick;
        logic [31:0] imm;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst_type = 3'd0; in_imm = 32'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_opcode = 7'd0;
        cur_lit_v = 1'b0; cur_lit_inst = 32'd0; cur_lit_err = 1'b0;

        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed vectors with hand-computed words.
        send(0, 32'h1234_5000, 5, 0, 0, 0, 7'h37, 1, 32'h1234_52B7, 1'b0);
        send(2, 32'hFFFF_FFFF, 2, 1, 0, 0, 7'h13, 1, 32'hFFF0_8113, 1'b0);
        send(2, 32'd2048,      2, 1, 0, 0, 7'h13, 1, 32'h0000_0013, 1'b1);
        send(4, 32'hFFFF_FFFC, 0, 1, 2, 1, 7'h63, 1, 32'hFE20_9EE3, 1'b0);
        send(4, 32'd6,         0, 1, 2, 1, 7'h63, 1, 32'h0020_9363, 1'b0);
        send(4, 32'd3,         0, 1, 2, 1, 7'h63, 1, 32'h0000_0013, 1'b1);
        send(1, 32'd2048,      1, 0, 0, 0, 7'h6F, 1, 32'h0010_00EF, 1'b0);
        send(3, 32'd8,         0, 2, 3, 2, 7'h23, 1, 32'h0031_2423, 1'b0);
        send(5, 32'd0,         1, 1, 1, 0, 7'h13, 1, 32'h0000_0013, 1'b1);
        send(0, 32'h0000_1001, 1, 0, 0, 0, 7'h37, 1, 32'h0000_0013, 1'b1);
        // Range boundaries.
        send(1, 32'h000F_FFFE, 3, 0, 0, 0, 7'h6F, 0, 32'd0, 1'b0);
        send(1, 32'h0010_0000, 3, 0, 0, 0, 7'h6F, 1, 32'h0000_0013, 1'b1);
        send(1, 32'hFFF0_0000, 3, 0, 0, 0, 7'h6F, 1, 32'h8000_01EF, 1'b0);
        send(4, 32'd4094,      0, 4, 5, 0, 7'h63, 0, 32'd0, 1'b0);
        send(4, 32'd4096,      0, 4, 5, 0, 7'h63, 1, 32'h0000_0013, 1'b1);
        send(4, 32'hFFFF_F000, 0, 4, 5, 0, 7'h63, 0, 32'd0, 1'b0);
        send(2, 32'hFFFF_F800, 7, 6, 0, 3, 7'h03, 1, 32'h8003_3383, 1'b0);
        send(3, 32'hFFFF_F7FF, 0, 6, 7, 2, 7'h23, 1, 32'h0000_0013, 1'b1);
        send(3, 32'd2047,      0, 6, 7, 2, 7'h23, 0, 32'd0, 1'b0);
        drain();

        // Backpressure: four requests against a stalled output for five cycles.
        out_ready = 1'b0;
        send(2, 32'd1, 1, 1, 0, 0, 7'h13, 1, 32'h0010_8093, 1'b0);
        send(2, 32'd2, 2, 2, 0, 0, 7'h13, 1, 32'h0021_0113, 1'b0);
        chk("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        fork
            begin
                send(2, 32'd3, 3, 3, 0, 0, 7'h13, 1, 32'h0031_8193, 1'b0);
                send(2, 32'd4, 4, 4, 0, 0, 7'h13, 1, 32'h0042_0213, 1'b0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Mixed burst against a randomly stalling consumer.
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    t    = $urandom_range(0, 5);
                    pick = $urandom_range(0, 3);
                    case (pick)
                        0: imm = $urandom_range(0, 4095);
                        1: imm = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
                        2: imm = 32'($urandom) & 32'hFFFF_F000;
                        default: imm = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
                    endcase
                    send(t, imm, $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
                         0, 32'd0, 1'b0);
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    out_ready = $urandom_range(0, 1) == 1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with two words in flight.
        out_ready = 1'b0;
        send(0, 32'hABCD_E000, 9, 0, 0, 0, 7'h17, 0, 32'd0, 1'b0);
        send(0, 32'h0000_1000, 9, 0, 0, 0, 7'h17, 0, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef RV_INST_ENC_STATS_EN
        chk("mid_rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
        model_enc = 0;
        model_err = 0;
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(3, 32'hFFFF_FFFF, 0, 1, 2, 0, 7'h23, 1, 32'hFE20_8FA3, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Inverse of the immediate decoder: packs a 32-bit immediate and register/opcode fields into an RV32I instruction word of type U/J/I/S/B.
- Two-stage valid/ready pipeline between the UART command parser and the instruction-memory loader.
- Performs immediate range and alignment checks. Illegal requests produce a flagged NOP instead of a corrupt encoding.

Parameters:
- NOP_INST, 32'h0000_0013, word emitted when a request fails its check (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_inst_type  in  3  0=U, 1=J, 2=I, 3=S, 4=B; 5..7 illegal
- in_imm  in  32  immediate as a signed byte value (U: full value with low 12 bits zero)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_opcode  in  7  opcode[6:0]
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts the word
- out_inst  out  32  encoded instruction
- out_err  out  1  request failed its check; out_inst = NOP_INST

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_inst=0, out_err=0, stage-1 valid=0.
  - in_ready=1 once rst_n=1.
- Handshakes:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Inputs are sampled only on a transfer.
- Pipeline:
  - S1 registers the request and the range-check result.
  - S2 registers the assembled word and the error flag.
  - Each stage loads when it is empty or its successor is loading.
  - in_ready = !s1_valid | s2_load.
  - Latency 2 cycles from input transfer to out_valid when out_ready=1. Sustains 1 word/cycle.
- Backpressure:
  - out_ready=0 holds out_inst/out_err/out_valid stable.
  - S1 fills, then in_ready drops. No request is lost or duplicated.
- Range checks (all signed):
  - U: in_imm[11:0]==0.
  - J: -2^20 <= imm <= 2^20-2, imm[0]==0.
  - I: -2048..2047.
  - S: -2048..2047.
  - B: -4096..4094, imm[0]==0.
  - Types 5..7 always fail.
- Assembly (opcode is always inst[6:0]):
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Failed check: out_inst=NOP_INST, out_err=1. Pipeline flow is unchanged.
- Unused fields of each type are ignored.
- Simultaneous output transfer and new input with full pipeline: S2 takes S1, S1 takes the new input, all in the same cycle.
- rst_n asserted mid-operation: all in-flight words are discarded immediately. No output after release until a new input.

Optional Feature:
- RV_INST_ENC_STATS_EN defined:
  - Adds outputs enc_count[15:0] and err_count[15:0].
  - Both increment on each output transfer (err_count only when out_err=1).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent. Encoding behaviour is identical.

Decomposition:
- Package rv_isa_pkg:
  - Type codes IMM_U=0, IMM_J=1, IMM_I=2, IMM_S=3, IMM_B=4.
  - Default NOP constant.
  - Range-limit constants.
- Sub-module rv_imm_range_chk (combinational): type + imm -> ok. Instantiated once, feeding S1.

Test Plan:
- U: type=0, imm=32'h12345000, rd=5, opcode=7'h37, out_ready=1 -> after 2 cycles out_inst=32'h123452B7, out_err=0.
- I: type=2, imm=-1, rs1=1, funct3=0, rd=2, opcode=7'h13 -> 32'hFFF08113. imm=2048 -> out_inst=32'h00000013, out_err=1.
- B: type=4, imm=-4, rs1=1, rs2=2, funct3=1, opcode=7'h63 -> 32'hFE209EE3. imm=6 is legal; imm=3 -> err.
- J: type=1, imm=2048, rd=1, opcode=7'h6F -> 32'h001000EF. S: type=3, imm=8, rs2=3, rs1=2, funct3=2, opcode=7'h23 -> 32'h00312423.
- Backpressure: 4 back-to-back requests, out_ready low 5 cycles:
  - in_ready drops after 2 accepted.
  - Outputs stay stable.
  - All 4 words emerge in order once out_ready=1.
- rst_n pulsed low with 2 words in flight -> out_valid=0 immediately. With RV_INST_ENC_STATS_EN, counters read 0.
